// File: rtl/raw_rx_fifo_writer_if.sv
// Word-stream and FIFO write-port bundle between the raw link receiver, the framer and the FIFO.
// master: the receiver + FIFO side; slave: the framer.
interface raw_rx_fifo_writer_if;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    logic [1:0]  in_bcnt;
    logic [31:0] in_data;
    logic        wfull;
    logic        almost_full;
    logic        w_en;
    logic [43:0] wdata;

    modport master (
        output in_valid, in_sop, in_eop, in_bcnt, in_data, wfull, almost_full,
        input  w_en, wdata
    );

    modport slave (
        input  in_valid, in_sop, in_eop, in_bcnt, in_data, wfull, almost_full,
        output w_en, wdata
    );
endinterface

// File: rtl/raw_rx_fifo_writer.sv
// Raw 10G receive framer: packs the non-stallable 32-bit word stream into 44-bit FIFO words,
// dropping whole frames when room is short at start and truncating with an error terminator mid-frame.
module raw_rx_fifo_writer #(
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 wclk,
    input  logic                 wrst,
    raw_rx_fifo_writer_if.slave  bus,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic [CNT_W-1:0]     trunc_cnt
);

    localparam int unsigned WCNT_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                term_q, term_d;
    logic [6:0]          seq_q, seq_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                ovalid_q, ovalid_d;
    logic [43:0]         odata_q, odata_d;
    logic [CNT_W-1:0]    frame_q, frame_d;
    logic [CNT_W-1:0]    drop_q, drop_d;
    logic [CNT_W-1:0]    trunc_q, trunc_d;

    logic                w_en_int;
    logic                load_ok;
    logic                load;
    logic [43:0]         load_word;
    logic [6:0]          frame_seq;
    logic [WCNT_W-1:0]   wcnt_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [43:0] mk_word(input logic sop, input logic eop, input logic err,
                                            input logic [1:0] bcnt, input logic [6:0] seq,
                                            input logic [31:0] data);
        return {sop, eop, err, bcnt, seq, data};
    endfunction

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q  <= IDLE;
            term_q   <= 1'b0;
            seq_q    <= '0;
            wcnt_q   <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            frame_q  <= '0;
            drop_q   <= '0;
            trunc_q  <= '0;
        end else begin
            state_q  <= state_d;
            term_q   <= term_d;
            seq_q    <= seq_d;
            wcnt_q   <= wcnt_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            frame_q  <= frame_d;
            drop_q   <= drop_d;
            trunc_q  <= trunc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        term_d    = term_q;
        seq_d     = seq_q;
        wcnt_d    = wcnt_q;
        frame_d   = frame_q;
        drop_d    = drop_q;
        trunc_d   = trunc_q;
        load      = 1'b0;
        load_word = '0;
        load_ok   = ~ovalid_q | w_en_int;
        // seq_q already points at the next frame; the open frame carries the previous value.
        frame_seq = seq_q - 7'd1;
        wcnt_nxt  = wcnt_q + WCNT_W'(1);

        if (term_q && load_ok) begin
            load      = 1'b1;
            load_word = mk_word(1'b0, 1'b1, 1'b1, 2'd0, frame_seq, 32'd0);
            term_d    = 1'b0;
        end

        if (bus.in_valid) begin
            case (state_q)
                IDLE: begin
                    if (bus.in_sop) begin
                        if (!bus.almost_full && !term_q && load_ok) begin
                            load      = 1'b1;
                            load_word = mk_word(1'b1, bus.in_eop, 1'b0,
                                                bus.in_eop ? bus.in_bcnt : 2'd0,
                                                seq_q, bus.in_data);
                            seq_d     = seq_q + 7'd1;
                            wcnt_d    = WCNT_W'(1);
                            if (bus.in_eop) frame_d = sat_inc(frame_q);
                            else            state_d = PASS;
                        end else begin
                            drop_d = sat_inc(drop_q);
                            if (!bus.in_eop) state_d = DROP;
                        end
                    end
                end
                PASS: begin
                    if (bus.in_sop) begin
                        term_d  = 1'b1;
                        trunc_d = sat_inc(trunc_q);
                        drop_d  = sat_inc(drop_q);
                        state_d = bus.in_eop ? IDLE : DROP;
                    end else if (!load_ok) begin
                        term_d  = 1'b1;
                        trunc_d = sat_inc(trunc_q);
                        state_d = bus.in_eop ? IDLE : DROP;
                    end else begin
                        load   = 1'b1;
                        wcnt_d = wcnt_nxt;
                        if (bus.in_eop) begin
                            load_word = mk_word(1'b0, 1'b1, 1'b0, bus.in_bcnt, frame_seq, bus.in_data);
                            frame_d   = sat_inc(frame_q);
                            state_d   = IDLE;
                        end else if (wcnt_nxt == WCNT_W'(MAX_WORDS)) begin
                            load_word = mk_word(1'b0, 1'b1, 1'b1, 2'd0, frame_seq, bus.in_data);
                            trunc_d   = sat_inc(trunc_q);
                            state_d   = DROP;
                        end else begin
                            load_word = mk_word(1'b0, 1'b0, 1'b0, 2'd0, frame_seq, bus.in_data);
                        end
                    end
                end
                DROP: begin
                    if (bus.in_eop) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (load) begin
            ovalid_d = 1'b1;
            odata_d  = load_word;
        end else begin
            ovalid_d = ovalid_q & ~w_en_int;
            odata_d  = odata_q;
        end
    end

    always_comb begin
        w_en_int  = ovalid_q & ~bus.wfull;
        bus.w_en  = w_en_int;
        bus.wdata = odata_q;
        frame_cnt = frame_q;
        drop_cnt  = drop_q;
        trunc_cnt = trunc_q;
    end

endmodule

// File: tb/tb_raw_rx_fifo_writer.sv
// Directed bench for raw_rx_fifo_writer: captures FIFO writes on the falling edge and
// compares them and the status counters against hand-computed words.
module tb_raw_rx_fifo_writer;

    localparam int unsigned MAXW = 256;
    localparam int unsigned CNTW = 16;

    logic            wclk = 1'b0;
    logic            wrst;
    logic [CNTW-1:0] frame_cnt, drop_cnt, trunc_cnt;

    raw_rx_fifo_writer_if bus();

    raw_rx_fifo_writer #(.MAX_WORDS(MAXW), .CNT_W(CNTW)) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .bus       (bus),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt),
        .trunc_cnt (trunc_cnt)
    );

    always #5 wclk = ~wclk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [43:0] wq[$];
    logic [43:0] exq[$];

    always @(negedge wclk) begin
        if (!wrst && bus.w_en) wq.push_back(bus.wdata);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [1:0] b, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_sop   = s;
        bus.in_eop   = e;
        bus.in_bcnt  = b;
        bus.in_data  = d;
        @(posedge wclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 64'(wq.size()), 64'(exq.size()));
        for (int i = 0; i < exq.size() && i < wq.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 64'(wq[i]), 64'(exq[i]));
        wq.delete();
        exq.delete();
    endtask

    initial begin
        wrst            = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_sop      = 1'b0;
        bus.in_eop      = 1'b0;
        bus.in_bcnt     = 2'd0;
        bus.in_data     = 32'd0;
        bus.wfull       = 1'b0;
        bus.almost_full = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        check("rst_wen",   64'(bus.w_en),  64'd0);
        check("rst_wdata", 64'(bus.wdata), 64'd0);
        check("rst_frame", 64'(frame_cnt), 64'd0);
        check("rst_drop",  64'(drop_cnt),  64'd0);
        check("rst_trunc", 64'(trunc_cnt), 64'd0);
        wrst = 1'b0;
        idle(2);

        // 4-word clean frame, seq 0
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'hA0);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'hB1);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'hC2);
        drive(1'b1, 1'b0, 1'b1, 2'd2, 32'hD3);
        idle(3);
        exq.push_back(44'h800_0000_00A0);
        exq.push_back(44'h000_0000_00B1);
        exq.push_back(44'h000_0000_00C2);
        exq.push_back(44'h500_0000_00D3);
        check_writes("f4");
        check("f4_frame", 64'(frame_cnt), 64'd1);

        // almost_full at sop drops the whole frame; next frame accepted with seq 1
        bus.almost_full = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h11);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h12);
        drive(1'b1, 1'b0, 1'b1, 2'd1, 32'h13);
        bus.almost_full = 1'b0;
        idle(2);
        check_writes("af_drop");
        check("af_drop_cnt", 64'(drop_cnt), 64'd1);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h21);
        drive(1'b1, 1'b0, 1'b1, 2'd3, 32'h22);
        idle(3);
        exq.push_back(44'h801_0000_0021);
        exq.push_back(44'h581_0000_0022);
        check_writes("af_next");
        check("af_frame", 64'(frame_cnt), 64'd2);

        // wfull from word 2 of a 10-word frame: overflow, then one terminator
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h31);
        bus.wfull = 1'b1;
        for (int i = 2; i <= 10; i++) begin
            drive(1'b1, 1'b0, (i == 10), 2'd0, 32'h30 + 32'(i));
            if (i == 5) check("ovf_wen_held", 64'(bus.w_en), 64'd0);
        end
        bus.wfull = 1'b0;
        idle(3);
        exq.push_back(44'h802_0000_0031);
        exq.push_back(44'h602_0000_0000);
        check_writes("ovf");
        check("ovf_trunc", 64'(trunc_cnt), 64'd1);
        check("ovf_frame", 64'(frame_cnt), 64'd2);

        // 300-word frame truncated at word 256
        for (int i = 1; i <= 300; i++)
            drive(1'b1, (i == 1), (i == 300), 2'd0, 32'h1000_0000 + 32'(i));
        idle(3);
        for (int i = 1; i <= 256; i++) begin
            logic [43:0] w;
            w = {(i == 1), (i == 256), (i == 256), 2'd0, 7'd3, 32'h1000_0000 + 32'(i)};
            exq.push_back(w);
        end
        check_writes("long");
        check("long_trunc", 64'(trunc_cnt), 64'd2);
        check("long_frame", 64'(frame_cnt), 64'd2);

        // sop at word 5 of an open frame
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h51);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h52);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h53);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h54);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h55);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h56);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h57);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h61);
        drive(1'b1, 1'b0, 1'b1, 2'd1, 32'h62);
        idle(3);
        exq.push_back(44'h804_0000_0051);
        exq.push_back(44'h004_0000_0052);
        exq.push_back(44'h004_0000_0053);
        exq.push_back(44'h004_0000_0054);
        exq.push_back(44'h604_0000_0000);
        exq.push_back(44'h805_0000_0061);
        exq.push_back(44'h485_0000_0062);
        check_writes("sop_mid");
        check("sop_mid_trunc", 64'(trunc_cnt), 64'd3);
        check("sop_mid_drop",  64'(drop_cnt),  64'd2);
        check("sop_mid_frame", 64'(frame_cnt), 64'd3);

        // reset mid-frame with a word held in the output register
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h71);
        check("pre_rst_wen", 64'(bus.w_en), 64'd1);
        #1 wrst = 1'b1;
        #1;
        check("mid_rst_wen",   64'(bus.w_en),  64'd0);
        check("mid_rst_wdata", 64'(bus.wdata), 64'd0);
        check("mid_rst_frame", 64'(frame_cnt), 64'd0);
        check("mid_rst_drop",  64'(drop_cnt),  64'd0);
        check("mid_rst_trunc", 64'(trunc_cnt), 64'd0);
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        @(posedge wclk);
        #2 wrst = 1'b0;
        @(posedge wclk);
        #1;
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h81);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h82);
        idle(3);
        exq.push_back(44'h800_0000_0081);
        exq.push_back(44'h400_0000_0082);
        check_writes("post_rst");
        check("post_rst_frame", 64'(frame_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
